// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: two-port round-robin arbiter/sequencer for the core-clock
// register bus. Pops one request at a time from two non-show-ahead FIFOs,
// runs it on the register bus and steers read results back to the requester.
// Optional watchdog: define REG_ARB_TIMEOUT_EN to compile in the abort path
// (counter, timeout_pulse). Without it REQ waits for reg_ack indefinitely.
module reg_bus_arbiter #(
    parameter int CPCI_NF2_ADDR_WIDTH = 27,
    parameter int CPCI_NF2_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES      = 255
) (
    input  logic                           core_clk,
    input  logic                           reset,
    // port 0 request FIFO / response
    input  logic                           fifo_empty_0,
    output logic                           fifo_rd_en_0,
    input  logic                           bus_rd_wr_L_0,
    input  logic [CPCI_NF2_ADDR_WIDTH-1:0] bus_addr_0,
    input  logic [CPCI_NF2_DATA_WIDTH-1:0] bus_wr_data_0,
    output logic [CPCI_NF2_DATA_WIDTH-1:0] bus_rd_data_0,
    output logic                           bus_rd_vld_0,
    // port 1 request FIFO / response
    input  logic                           fifo_empty_1,
    output logic                           fifo_rd_en_1,
    input  logic                           bus_rd_wr_L_1,
    input  logic [CPCI_NF2_ADDR_WIDTH-1:0] bus_addr_1,
    input  logic [CPCI_NF2_DATA_WIDTH-1:0] bus_wr_data_1,
    output logic [CPCI_NF2_DATA_WIDTH-1:0] bus_rd_data_1,
    output logic                           bus_rd_vld_1,
    // register-processing side
    output logic                           reg_req,
    output logic                           reg_rd_wr_L,
    output logic [CPCI_NF2_ADDR_WIDTH-1:0] reg_addr,
    output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_wr_data,
    input  logic                           reg_ack,
    input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_rd_data,
    output logic                           timeout_pulse
);

    localparam int DW = CPCI_NF2_DATA_WIDTH;

    // Read data returned to the requester when the watchdog aborts a read
    localparam logic [DW-1:0] ABORT_DATA = DW'(32'hDEAD_BEEF);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LATCH = 3'd2,
        REQ   = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t        state, next_state;
    logic          gnt, next_gnt;     // port owning the current transaction
    logic          last_grant;        // port granted most recently
    logic          pick;              // round-robin choice while IDLE
    logic          to_expire;         // watchdog limit reached this REQ cycle
    logic          rsp_done;          // REQ -> RESP this cycle
    logic [DW-1:0] rsp_data;

`ifdef REG_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] to_cnt;

    // Watchdog: zeroed just before REQ, counts REQ cycles without an ack
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset)
            to_cnt <= 8'd0;
        else if (state == LATCH)
            to_cnt <= 8'd0;
        else if (state == REQ && !reg_ack)
            to_cnt <= to_cnt + 8'd1;
    end

    // An ack in the expiry cycle still completes normally
    assign to_expire = (to_cnt == TO_LAST) && !reg_ack;

    // One pulse per aborted transaction, aligned with the RESP cycle
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset)
            timeout_pulse <= 1'b0;
        else
            timeout_pulse <= rsp_done && !reg_ack;
    end
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign to_expire          = 1'b0;
    assign timeout_pulse      = 1'b0;
`endif

    // Both FIFOs pending: alternate away from last winner; else take the busy one
    assign pick = (!fifo_empty_0 && !fifo_empty_1) ? ~last_grant : fifo_empty_0;

    // Next-state and grant selection
    always_comb begin
        next_state = state;
        next_gnt   = gnt;
        case (state)
            IDLE: begin
                if (!fifo_empty_0 || !fifo_empty_1) begin
                    next_state = POP;
                    next_gnt   = pick;
                end
            end
            POP:   next_state = LATCH;
            LATCH: next_state = REQ;
            REQ: begin
                if (reg_ack || to_expire)
                    next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign rsp_done = (state == REQ) && (next_state == RESP);
    assign rsp_data = reg_ack ? reg_rd_data : ABORT_DATA;

    // State, grant and round-robin history
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= next_state;
            gnt   <= next_gnt;
            if (state == IDLE && next_state == POP)
                last_grant <= next_gnt;
        end
    end

    // FIFO pop strobes: high for the single POP cycle of the granted port
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            fifo_rd_en_0 <= 1'b0;
            fifo_rd_en_1 <= 1'b0;
        end else begin
            fifo_rd_en_0 <= (next_state == POP) && !next_gnt;
            fifo_rd_en_1 <= (next_state == POP) &&  next_gnt;
        end
    end

    // Request fields: captured from FIFO q in LATCH, held through REQ and after
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            reg_req     <= 1'b0;
            reg_rd_wr_L <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
        end else begin
            reg_req <= (next_state == REQ);
            if (state == LATCH) begin
                reg_rd_wr_L <= gnt ? bus_rd_wr_L_1 : bus_rd_wr_L_0;
                reg_addr    <= gnt ? bus_addr_1    : bus_addr_0;
                reg_wr_data <= gnt ? bus_wr_data_1 : bus_wr_data_0;
            end
        end
    end

    // Read responses: strobe plus data, data held until that port's next read
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            bus_rd_vld_0  <= 1'b0;
            bus_rd_vld_1  <= 1'b0;
            bus_rd_data_0 <= '0;
            bus_rd_data_1 <= '0;
        end else begin
            bus_rd_vld_0 <= rsp_done && reg_rd_wr_L && !gnt;
            bus_rd_vld_1 <= rsp_done && reg_rd_wr_L &&  gnt;
            if (rsp_done && reg_rd_wr_L && !gnt)
                bus_rd_data_0 <= rsp_data;
            if (rsp_done && reg_rd_wr_L && gnt)
                bus_rd_data_1 <= rsp_data;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: FIFO and register-slave models, a timestamp
// based transaction model checked every cycle, and directed scenarios.
module tb_reg_bus_arbiter;

    localparam int AW = 27;
    localparam int DW = 32;
    localparam int TO = 10;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic          core_clk = 1'b0;
    logic          reset    = 1'b1;
    logic          fifo_empty_0, fifo_empty_1;
    logic          fifo_rd_en_0, fifo_rd_en_1;
    logic          bus_rd_wr_L_0 = 1'b0, bus_rd_wr_L_1 = 1'b0;
    logic [AW-1:0] bus_addr_0 = '0, bus_addr_1 = '0;
    logic [DW-1:0] bus_wr_data_0 = '0, bus_wr_data_1 = '0;
    logic [DW-1:0] bus_rd_data_0, bus_rd_data_1;
    logic          bus_rd_vld_0, bus_rd_vld_1;
    logic          reg_req, reg_rd_wr_L, reg_ack, timeout_pulse;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wr_data, reg_rd_data;

    always #5 core_clk = ~core_clk;

    reg_bus_arbiter #(
        .CPCI_NF2_ADDR_WIDTH(AW),
        .CPCI_NF2_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .core_clk(core_clk), .reset(reset),
        .fifo_empty_0(fifo_empty_0), .fifo_rd_en_0(fifo_rd_en_0),
        .bus_rd_wr_L_0(bus_rd_wr_L_0), .bus_addr_0(bus_addr_0),
        .bus_wr_data_0(bus_wr_data_0), .bus_rd_data_0(bus_rd_data_0),
        .bus_rd_vld_0(bus_rd_vld_0),
        .fifo_empty_1(fifo_empty_1), .fifo_rd_en_1(fifo_rd_en_1),
        .bus_rd_wr_L_1(bus_rd_wr_L_1), .bus_addr_1(bus_addr_1),
        .bus_wr_data_1(bus_wr_data_1), .bus_rd_data_1(bus_rd_data_1),
        .bus_rd_vld_1(bus_rd_vld_1),
        .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L), .reg_addr(reg_addr),
        .reg_wr_data(reg_wr_data), .reg_ack(reg_ack), .reg_rd_data(reg_rd_data),
        .timeout_pulse(timeout_pulse)
    );

    // ---------------- request FIFOs (q valid the cycle after rd_en) ----------
    ent_t q0[$];
    ent_t q1[$];
    assign fifo_empty_0 = (q0.size() == 0);
    assign fifo_empty_1 = (q1.size() == 0);

    always @(posedge core_clk) begin
        if (fifo_rd_en_0 && q0.size() > 0) begin
            bus_rd_wr_L_0 <= q0[0].rw;
            bus_addr_0    <= q0[0].addr;
            bus_wr_data_0 <= q0[0].data;
            q0.pop_front();
        end
        if (fifo_rd_en_1 && q1.size() > 0) begin
            bus_rd_wr_L_1 <= q1[0].rw;
            bus_addr_1    <= q1[0].addr;
            bus_wr_data_1 <= q1[0].data;
            q1.pop_front();
        end
    end

    // ---------------- register slave: ack on the ack_at-th REQ cycle --------
    int            ack_at = 0;
    int            req_n  = 0;
    logic          slv_ack = 1'b0;
    logic          spur_ack = 1'b0;
    logic [DW-1:0] rd_data_drv = '0;
    assign reg_ack     = slv_ack | spur_ack;
    assign reg_rd_data = rd_data_drv;

    always @(negedge core_clk) begin
        if (reg_req) begin
            req_n   <= req_n + 1;
            slv_ack <= (ack_at != 0) && (req_n + 1 == ack_at);
        end else begin
            req_n   <= 0;
            slv_ack <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Model: a transaction granted at cycle s pops at s+1, requests from s+3
    // until the ack/abort cycle e, responds at e+1, and the bus is free at e+2.
    bit            m_act = 0, m_ab = 0, m_last = 1;
    int            s = -1, e = -1, mp = 0, done_cnt = 0;
    ent_t          ment;
    logic [DW-1:0] mrd = '0, xd0 = '0, xd1 = '0, xwd = '0;
    logic [AW-1:0] xa = '0;
    logic          xrw = 1'b0;
    bit            ex_rd0, ex_rd1, ex_rq, ex_v0, ex_v1, ex_tp;
    // observation logs for the literal checks
    int            g_log[$];
    logic [DW-1:0] wd_log[$];
    int            rlen_log[$];
    int            n_rd0 = 0, n_rd1 = 0, n_v0 = 0, n_v1 = 0, n_tp = 0, rlen = 0;
    logic          prev_req = 1'b0;

    always @(negedge core_clk) begin
        #1;
        cyc++;
        if (reset) begin
            m_act = 0; s = -1; e = -1; m_last = 1;
            xa = '0; xwd = '0; xrw = 1'b0; xd0 = '0; xd1 = '0;
            prev_req = 1'b0; rlen = 0;
        end else begin
            ex_rd0 = m_act && cyc == s + 1 && mp == 0;
            ex_rd1 = m_act && cyc == s + 1 && mp == 1;
            ex_rq  = m_act && cyc >= s + 3 && (e < 0 || cyc <= e);
            if (m_act && cyc == s + 3) begin
                xa = ment.addr; xwd = ment.data; xrw = ment.rw;
            end
            ex_v0 = m_act && e >= 0 && cyc == e + 1 && mp == 0 && ment.rw;
            ex_v1 = m_act && e >= 0 && cyc == e + 1 && mp == 1 && ment.rw;
            ex_tp = m_act && e >= 0 && cyc == e + 1 && m_ab;
            if (ex_v0) xd0 = mrd;
            if (ex_v1) xd1 = mrd;

            chk("fifo_rd_en_0", fifo_rd_en_0, ex_rd0);
            chk("fifo_rd_en_1", fifo_rd_en_1, ex_rd1);
            chk("reg_req", reg_req, ex_rq);
            chk("reg_rd_wr_L", reg_rd_wr_L, xrw);
            chk("reg_addr", reg_addr, xa);
            chk("reg_wr_data", reg_wr_data, xwd);
            chk("bus_rd_vld_0", bus_rd_vld_0, ex_v0);
            chk("bus_rd_vld_1", bus_rd_vld_1, ex_v1);
            chk("bus_rd_data_0", bus_rd_data_0, xd0);
            chk("bus_rd_data_1", bus_rd_data_1, xd1);
            chk("timeout_pulse", timeout_pulse, ex_tp);

            if (fifo_rd_en_0) begin g_log.push_back(0); n_rd0++; end
            if (fifo_rd_en_1) begin g_log.push_back(1); n_rd1++; end
            if (bus_rd_vld_0) n_v0++;
            if (bus_rd_vld_1) n_v1++;
            if (timeout_pulse) n_tp++;
            if (reg_req && !prev_req) wd_log.push_back(reg_wr_data);
            if (reg_req) rlen++;
            if (!reg_req && prev_req) begin rlen_log.push_back(rlen); rlen = 0; end
            prev_req = reg_req;

            if (m_act && e < 0 && ex_rq) begin
                if (reg_ack) begin
                    e = cyc; m_ab = 0; mrd = reg_rd_data;
                end
`ifdef REG_ARB_TIMEOUT_EN
                else if (cyc - (s + 3) == TO - 1) begin
                    e = cyc; m_ab = 1; mrd = 32'hDEAD_BEEF;
                end
`endif
            end else if (m_act && e >= 0 && cyc == e + 1) begin
                m_act = 0;
                done_cnt++;
            end else if (!m_act && (q0.size() > 0 || q1.size() > 0)) begin
                if (q0.size() > 0 && q1.size() > 0) mp = m_last ? 0 : 1;
                else                                  mp = (q0.size() > 0) ? 0 : 1;
                m_last = mp[0];
                ment   = (mp == 0) ? q0[0] : q1[0];
                s = cyc; e = -1; m_act = 1;
            end
        end
    end

    // Wait (bounded) until the model has seen n completed transactions
    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            @(negedge core_clk);
            k++;
        end
        chk("wait_done", 64'(done_cnt >= n), 64'd1);
        @(negedge core_clk);
    endtask

    int nd = 0;
    int gl, b_rd0, b_rd1, b_v0, b_v1, b_tp;
    int exp_g[6];
    logic [DW-1:0] exp_wd[6];

    initial begin
        exp_g  = '{0, 1, 0, 1, 0, 1};
        exp_wd = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202};
        repeat (3) @(negedge core_clk);
        reset = 1'b0;
        #2;
        chk("rst_reg_req", reg_req, 0);
        chk("rst_rd_data_0", bus_rd_data_0, 0);
        chk("rst_timeout", timeout_pulse, 0);
        @(negedge core_clk);

        // both FIFOs with three writes each: strict alternation from port 0
        ack_at = 1;
        for (int i = 0; i < 3; i++) begin
            q0.push_back('{1'b0, AW'(32'h20 + i), DW'(32'h100 + i)});
            q1.push_back('{1'b0, AW'(32'h40 + i), DW'(32'h200 + i)});
        end
        nd += 6;
        wait_done(nd, 100);
        chk("grant_count", g_log.size(), 6);
        for (int i = 0; i < 6 && i < g_log.size(); i++) chk("grant_order", g_log[i], exp_g[i]);
        for (int i = 0; i < 6 && i < wd_log.size(); i++) chk("wr_data_order", wd_log[i], exp_wd[i]);
        chk("writes_no_vld", n_v0 + n_v1, 0);

        // single read on port 0, ack on the 3rd REQ cycle
        b_rd0 = n_rd0; b_rd1 = n_rd1; b_v0 = n_v0;
        ack_at = 3; rd_data_drv = 32'h1234_5678;
        q0.push_back('{1'b1, 27'h0000010, 32'h0});
        nd++;
        wait_done(nd, 50);
        chk("rd0_pop_once", n_rd0 - b_rd0, 1);
        chk("rd0_vld_once", n_v0 - b_v0, 1);
        chk("rd0_data", bus_rd_data_0, 32'h1234_5678);
        chk("rd0_addr", reg_addr, 27'h0000010);
        chk("rd0_req_len", rlen_log[$], 3);
        chk("rd0_port1_pop", n_rd1 - b_rd1, 0);
        chk("rd0_port1_vld", n_v1, 0);
        chk("rd0_port1_data", bus_rd_data_1, 0);

`ifdef REG_ARB_TIMEOUT_EN
        // read on port 1 with no ack: abort after TO request cycles
        b_v1 = n_v1;
        ack_at = 0;
        q1.push_back('{1'b1, 27'h0000030, 32'h0});
        nd++;
        wait_done(nd, 60);
        chk("to_req_len", rlen_log[$], TO);
        chk("to_pulse", n_tp, 1);
        chk("to_vld1", n_v1 - b_v1, 1);
        chk("to_data1", bus_rd_data_1, 32'hDEAD_BEEF);
        // next request completes normally
        ack_at = 2; rd_data_drv = 32'h0000_0077;
        q0.push_back('{1'b1, 27'h0000031, 32'h0});
        nd++;
        wait_done(nd, 50);
        chk("after_to_data0", bus_rd_data_0, 32'h0000_0077);
        chk("after_to_no_pulse", n_tp, 1);
`endif

        // ack coincides with the last allowed REQ cycle: ack wins
        b_tp = n_tp;
        ack_at = TO; rd_data_drv = 32'hCAFE_F00D;
        q1.push_back('{1'b1, 27'h0000040, 32'h0});
        nd++;
        wait_done(nd, 60);
        chk("edge_ack_data1", bus_rd_data_1, 32'hCAFE_F00D);
        chk("edge_ack_len", rlen_log[$], TO);
        chk("edge_ack_no_pulse", n_tp - b_tp, 0);

        // spurious ack while idle, then a normal read
        b_v0 = n_v0; b_v1 = n_v1;
        rd_data_drv = 32'h1111_1111;
        spur_ack = 1'b1;
        @(negedge core_clk);
        spur_ack = 1'b0;
        repeat (2) @(negedge core_clk);
        chk("spur_no_vld", (n_v0 - b_v0) + (n_v1 - b_v1), 0);
        chk("spur_req_low", reg_req, 0);
        ack_at = 2; rd_data_drv = 32'hA5A5_A5A5;
        q0.push_back('{1'b1, 27'h0000050, 32'h0});
        nd++;
        wait_done(nd, 50);
        chk("spur_then_read", bus_rd_data_0, 32'hA5A5_A5A5);

        // reset in the middle of REQ
        ack_at = 0;
        q0.push_back('{1'b1, 27'h0000060, 32'h0});
        begin
            int k = 0;
            while (!reg_req && k < 20) begin @(negedge core_clk); k++; end
        end
        chk("rst_mid_req_seen", reg_req, 1);
        repeat (2) @(negedge core_clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reg_req", reg_req, 0);
        chk("async_reg_addr", reg_addr, 0);
        chk("async_rd_wr_L", reg_rd_wr_L, 0);
        chk("async_rd_data_0", bus_rd_data_0, 0);
        chk("async_rd_en_0", fifo_rd_en_0, 0);
        chk("async_vld_0", bus_rd_vld_0, 0);
        chk("async_timeout", timeout_pulse, 0);
        @(negedge core_clk);
        ack_at = 1;
        q1.push_back('{1'b0, 27'h0000070, 32'h7});
        q0.push_back('{1'b0, 27'h0000071, 32'h8});
        gl = g_log.size();
        @(negedge core_clk);
        reset = 1'b0;
        nd += 2;
        wait_done(nd, 50);
        chk("post_rst_grants", g_log.size() - gl, 2);
        if (g_log.size() >= gl + 2) begin
            chk("post_rst_first", g_log[gl], 0);
            chk("post_rst_second", g_log[gl + 1], 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
